wb_timer: RTL and testbench

WB_TIMER -- requirements
Module: wb_timer

---
 rtl/wb_timer_pkg.sv | 32 +++
 rtl/wb_timer_prescaler.sv | 30 +++
 rtl/wb_timer.sv | 161 ++++++++++++++++
 tb/tb_wb_timer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_timer_pkg.sv
// Shared definitions for the Wishbone timer: register map, control/status
// bit positions, peripheral base address and a byte-lane merge helper.
package wb_timer_pkg;

  // Byte address of the timer block on the system bus.
  localparam logic [31:0] WB_TIMER_BASE = 32'hFFFF_F100;

  // Register offsets, selected by word-address bits [2:0].
  localparam logic [2:0] REG_CNT  = 3'd0;
  localparam logic [2:0] REG_LIM  = 3'd1;
  localparam logic [2:0] REG_CTL  = 3'd2;
  localparam logic [2:0] REG_STAT = 3'd3;
  localparam logic [2:0] REG_CAP  = 3'd4;

  // Control and status bit positions.
  localparam int CTL_EN_BIT    = 0;
  localparam int CTL_AUTO_BIT  = 1;
  localparam int STAT_DONE_BIT = 0;

  // Replace only the byte lanes enabled in sel.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_timer_prescaler.sv
// Clock prescaler for the Wishbone timer: emits a one-cycle tick every
// PRESCALE enabled cycles and returns to zero whenever it is disabled.
module timer_prescaler #(
  parameter int unsigned PRESCALE = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Next count: wrap after the terminal value, park at zero while disabled.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!en_i || (cnt_q == LAST)) cnt_d = '0;
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_timer.sv
// Wishbone timer peripheral: CNT/LIM/CTL/STAT registers, prescaled tick,
// one-shot or auto-reload operation and a DONE level interrupt.
// Optional capture register (CAP) and i_capture edge detector are built
// only when the macro WB_TIMER_CAPTURE_EN is defined.
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int unsigned PRESCALE  = 50,
  parameter logic [31:0] RESET_LIM = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [29:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [3:0]  i_wb_sel,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  input  logic        i_capture,
  output logic        o_irq
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] lim_q, lim_d;
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        done_q, done_d;
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d;

  logic        req, wr, tick, hit;
  logic [2:0]  off;

  assign req  = i_wb_cyc && i_wb_stb;
  assign wr   = req && i_wb_we;
  assign off  = i_wb_addr[2:0];
  assign hit  = tick && (cnt_q == lim_q);

  timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk_i  (i_clk),
    .rst_i  (i_reset),
    .en_i   (en_q),
    .tick_o (tick)
  );

`ifdef WB_TIMER_CAPTURE_EN
  logic [31:0] cap_q;
  logic        capt_prev_q;

  // Latch CNT on each rising edge of the capture strobe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cap_q       <= '0;
      capt_prev_q <= 1'b0;
    end else begin
      capt_prev_q <= i_capture;
      if (i_capture && !capt_prev_q) cap_q <= cnt_q;
    end
  end
`endif

  // Upper address bits are decoded outside this block.
  logic unused_bits;
`ifdef WB_TIMER_CAPTURE_EN
  assign unused_bits = ^i_wb_addr[29:3];
`else
  assign unused_bits = ^{i_wb_addr[29:3], i_capture};
`endif

  // Register next state: bus writes win over tick updates on CNT and CTL,
  // while a DONE set wins over a same-cycle write-1-to-clear.
  always_comb begin
    cnt_d  = cnt_q;
    lim_d  = lim_q;
    en_d   = en_q;
    auto_d = auto_q;
    done_d = done_q;

    if (wr && off == REG_CNT) begin
      cnt_d = byte_merge(cnt_q, i_wb_data, i_wb_sel);
    end else if (tick) begin
      if (hit) begin
        if (auto_q) cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    if (wr && off == REG_LIM) lim_d = byte_merge(lim_q, i_wb_data, i_wb_sel);

    if (wr && off == REG_CTL && i_wb_sel[0]) begin
      en_d   = i_wb_data[CTL_EN_BIT];
      auto_d = i_wb_data[CTL_AUTO_BIT];
    end else if (hit && !auto_q) begin
      en_d = 1'b0;
    end

    if (hit) begin
      done_d = 1'b1;
    end else if (wr && off == REG_STAT && i_wb_sel[0] && i_wb_data[STAT_DONE_BIT]) begin
      done_d = 1'b0;
    end
  end

  // Read mux: value returned in the ack cycle, zero for writes and idle cycles.
  always_comb begin
    rdata_d = '0;
    if (req && !i_wb_we) begin
      case (off)
        REG_CNT:  rdata_d = cnt_q;
        REG_LIM:  rdata_d = lim_q;
        REG_CTL: begin
          rdata_d[CTL_EN_BIT]   = en_q;
          rdata_d[CTL_AUTO_BIT] = auto_q;
        end
        REG_STAT: rdata_d[STAT_DONE_BIT] = done_q;
`ifdef WB_TIMER_CAPTURE_EN
        REG_CAP:  rdata_d = cap_q;
`endif
        default:  rdata_d = '0;
      endcase
    end
  end

  // Timer registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q  <= '0;
      lim_q  <= RESET_LIM;
      en_q   <= 1'b0;
      auto_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lim_q  <= lim_d;
      en_q   <= en_d;
      auto_q <= auto_d;
      done_q <= done_d;
    end
  end

  // Bus response: ack and data one cycle after each strobe, dropped by reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= req;
      rdata_q <= rdata_d;
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_data  = rdata_q;
  assign o_wb_stall = 1'b0;
  assign o_irq      = done_q;

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: behavioural model plus per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_timer;
  import wb_timer_pkg::*;

  localparam int          P     = 4;
  localparam logic [31:0] RLIM  = 32'hFFFF_FFFF;
  localparam logic [29:0] WBASE = 30'(WB_TIMER_BASE >> 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        cap_in = 1'b0;
  logic        ack, stall, irq;
  logic [31:0] rdat;

  always #5 clk = ~clk;

  wb_timer #(.PRESCALE(P), .RESET_LIM(RLIM)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_wb_cyc  (cyc),
    .i_wb_stb  (stb),
    .i_wb_we   (we),
    .i_wb_addr (addr),
    .i_wb_data (wdat),
    .i_wb_sel  (sel),
    .o_wb_ack  (ack),
    .o_wb_stall(stall),
    .o_wb_data (rdat),
    .i_capture (cap_in),
    .o_irq     (irq)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_cnt, m_lim, m_cap, m_rdata;
  logic        m_en, m_auto, m_done, m_capprev, m_ack, m_rd;
  int          m_run;          // consecutive cycles EN has been on
  bit          m_valid = 0;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return (o & ~m) | (n & m);
  endfunction

  function automatic logic [31:0] view(input logic [2:0] o);
    case (o)
      3'd0: return m_cnt;
      3'd1: return m_lim;
      3'd2: return {30'd0, m_auto, m_en};
      3'd3: return {31'd0, m_done};
`ifdef WB_TIMER_CAPTURE_EN
      3'd4: return m_cap;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    bit          rq, w, tk, h;
    logic [2:0]  o;
    logic [31:0] n_cnt, n_lim;
    logic        n_en, n_auto, n_done;
    if (rst) begin
      m_cnt = 0; m_lim = RLIM; m_en = 0; m_auto = 0; m_done = 0;
      m_cap = 0; m_capprev = 0; m_run = 0; m_ack = 0; m_rd = 0; m_rdata = 0;
      m_valid = 1;
      return;
    end
    rq = cyc && stb;
    w  = rq && we;
    o  = addr[2:0];
    tk = m_en && (m_run % P == P - 1);
    h  = tk && (m_cnt == m_lim);
    m_ack   = rq;
    m_rd    = rq && !we;
    m_rdata = m_rd ? view(o) : 32'd0;

    n_cnt = m_cnt;
    if (w && o == 3'd0)      n_cnt = lanes(m_cnt, wdat, sel);
    else if (h)              n_cnt = m_auto ? 32'd0 : m_cnt;
    else if (tk)             n_cnt = m_cnt + 32'd1;
    n_lim = (w && o == 3'd1) ? lanes(m_lim, wdat, sel) : m_lim;
    n_en = m_en; n_auto = m_auto;
    if (w && o == 3'd2 && sel[0]) begin n_en = wdat[0]; n_auto = wdat[1]; end
    else if (h && !m_auto) n_en = 0;
    n_done = m_done;
    if (h) n_done = 1;
    else if (w && o == 3'd3 && sel[0] && wdat[0]) n_done = 0;
`ifdef WB_TIMER_CAPTURE_EN
    if (cap_in && !m_capprev) m_cap = m_cnt;
`endif
    m_capprev = cap_in;
    m_run  = m_en ? m_run + 1 : 0;
    m_cnt  = n_cnt; m_lim = n_lim; m_en = n_en; m_auto = n_auto; m_done = n_done;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare DUT outputs against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("ack", {31'd0, ack}, {31'd0, m_ack});
      check("irq", {31'd0, irq}, {31'd0, m_done});
      check("stall", {31'd0, stall}, 32'd0);
      if (!ack)      check("data_idle", rdat, 32'd0);
      else if (m_rd) check("rdata", rdat, m_rdata);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic idle(input int n);
    cyc = 0; stb = 0; we = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr_reg(input logic [2:0] o, input logic [31:0] d, input logic [3:0] s = 4'hF);
    cyc = 1; stb = 1; we = 1; addr = WBASE | 30'(o); wdat = d; sel = s;
    @(posedge clk); #1;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic rd_reg(input logic [2:0] o, output logic [31:0] d);
    cyc = 1; stb = 1; we = 0; addr = WBASE | 30'(o); sel = 4'hF;
    @(posedge clk); #1;
    cyc = 0; stb = 0;
    d = rdat;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    logic [31:0] seq [20];
    int          nseq, k;

    repeat (3) begin @(posedge clk); #1; end
    rst = 0;

    // Reset values, including unmapped offsets.
    for (int i = 0; i < 8; i++) begin
      rd_reg(3'(i), v);
      check($sformatf("reset_off%0d", i), v, (i == 1) ? RLIM : 32'd0);
    end

    // Strobe in the same cycle as reset: no ack afterwards.
    cyc = 1; stb = 1; we = 0; addr = WBASE; rst = 1;
    @(posedge clk); #1;
    check("ack_after_reset_req", {31'd0, ack}, 32'd0);
    rst = 0;
    @(posedge clk); #1;          // normal request sampled, ack now high
    rst = 1;
    @(posedge clk); #1;          // reset during the ack cycle
    check("ack_dropped_by_reset", {31'd0, ack}, 32'd0);
    rst = 0; cyc = 0; stb = 0;
    @(posedge clk); #1;
    check("no_ack_after_reset", {31'd0, ack}, 32'd0);

    // One-shot: LIM=3, EN=1 -> DONE 16 cycles after the CTL ack.
    wr_reg(REG_LIM, 32'd3);
    wr_reg(REG_CTL, 32'd1);
    k = 0;
    while (!irq && k < 100) begin @(posedge clk); #1; k++; end
    check("done_latency", k, 32'd16);
    rd_reg(REG_CNT, v);  check("oneshot_cnt", v, 32'd3);
    rd_reg(REG_CTL, v);  check("oneshot_ctl", v, 32'd0);
    rd_reg(REG_STAT, v); check("oneshot_stat", v, 32'd1);

    // Auto-reload: LIM=1 -> CNT 0,1,0,1 on successive ticks.
    wr_reg(REG_STAT, 32'd1);
    wr_reg(REG_CNT, 32'd0);
    wr_reg(REG_LIM, 32'd1);
    wr_reg(REG_CTL, 32'd3);
    nseq = 0;
    for (int i = 0; i < 20; i++) begin
      rd_reg(REG_CNT, v);
      if (nseq == 0 || seq[nseq-1] != v) begin seq[nseq] = v; nseq++; end
    end
    check("auto_seq_len_ge4", {31'd0, nseq >= 4}, 32'd1);
    for (int i = 0; i < 4; i++) check($sformatf("auto_seq%0d", i), seq[i], 32'(i % 2));
    check("auto_done", {31'd0, irq}, 32'd1);
    wr_reg(REG_CTL, 32'd0);

    // Top of range: no wrap through zero.
    wr_reg(REG_STAT, 32'd1);
    wr_reg(REG_LIM, 32'hFFFF_FFFF);
    wr_reg(REG_CNT, 32'hFFFF_FFFE);
    wr_reg(REG_CTL, 32'd1);
    idle(5);
    rd_reg(REG_CNT, v);  check("top_cnt_first_tick", v, 32'hFFFF_FFFF);
    rd_reg(REG_STAT, v); check("top_stat_first_tick", v, 32'd0);
    idle(10);
    rd_reg(REG_CNT, v);  check("top_cnt_hold", v, 32'hFFFF_FFFF);
    rd_reg(REG_STAT, v); check("top_stat_done", v, 32'd1);

    // DONE set beats a same-cycle write-1-to-clear.
    wr_reg(REG_STAT, 32'd1);
    wr_reg(REG_CNT, 32'd5);
    wr_reg(REG_LIM, 32'd5);
    wr_reg(REG_CTL, 32'd1);
    idle(3);
    wr_reg(REG_STAT, 32'd1);     // lands on the tick that sets DONE
    rd_reg(REG_STAT, v); check("w1c_collide", v, 32'd1);
    wr_reg(REG_STAT, 32'd1);
    rd_reg(REG_STAT, v); check("w1c_later", v, 32'd0);

    // Byte-lane write.
    wr_reg(REG_CNT, 32'h1122_3344);
    wr_reg(REG_CNT, 32'h0000_AB00, 4'b0010);
    rd_reg(REG_CNT, v); check("byte_lane", v, 32'h1122_AB44);

    // Unmapped write ignored; CTL upper bits read 0.
    wr_reg(3'd5, 32'hFFFF_FFFF);
    rd_reg(3'd5, v); check("unmapped_rd", v, 32'd0);
    wr_reg(REG_CTL, 32'hFFFF_FFFE);
    rd_reg(REG_CTL, v); check("ctl_mask", v, 32'd2);
    wr_reg(REG_CTL, 32'd0);

    // Capture.
    wr_reg(REG_CNT, 32'd7);
    cap_in = 1; @(posedge clk); #1; cap_in = 0;
    idle(1);
    rd_reg(REG_CAP, v);
`ifdef WB_TIMER_CAPTURE_EN
    check("capture", v, 32'd7);
`else
    check("capture_absent", v, 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      cyc    = ($urandom_range(0, 7) != 0);
      stb    = ($urandom_range(0, 2) != 0);
      we     = $urandom_range(0, 1) == 1;
      addr   = {27'($urandom), 3'($urandom_range(0, 7))};
      wdat   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 5)) : $urandom;
      sel    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      cap_in = $urandom_range(0, 1) == 1;
      @(posedge clk); #1;
    end
    rst = 0; cap_in = 0;
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
